// File: rtl/branch_decision_unit.sv
// rtl/branch_decision_unit.sv - RISC-V conditional-branch outcome resolver
//
// Turns the single-bit ALU compare result and the branch func3 field into a
// taken decision. A combinational copy feeds same-cycle PC redirect; a
// registered copy (qualified by i_valid) feeds writeback/commit.
//
// Ports:
//   i_clk        system clock, rising-edge active
//   i_rst_n      asynchronous active-low reset
//   i_valid      a branch instruction is present this cycle
//   i_result     ALU compare result (eq / signed lt / unsigned lt)
//   i_func3      branch func3 field
//   o_branch     combinational taken decision
//   o_illegal    combinational flag, func3 is 010 or 011
//   o_branch_q   registered o_branch & i_valid
//   o_illegal_q  registered o_illegal & i_valid
//   o_valid_q    registered i_valid
//   o_taken_cnt  saturating count of taken branches   (BRANCH_STATS_EN)
//   o_total_cnt  saturating count of legal branches   (BRANCH_STATS_EN)
//
// Optional feature macro: BRANCH_STATS_EN adds the statistics counters.

module branch_decision_unit #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_result,
    input  logic [2:0]       i_func3,
    output logic             o_branch,
    output logic             o_illegal,
    output logic             o_branch_q,
    output logic             o_illegal_q,
`ifdef BRANCH_STATS_EN
    output logic             o_valid_q,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_total_cnt
`else
    output logic             o_valid_q
`endif
);

    // func3[0] selects the inverted sense (BNE/BGE/BGEU); the ALU already
    // picked eq / slt / sltu from func3[2:1], so only the polarity is applied
    // here. 010/011 are reserved encodings and never take the branch.
    always_comb begin
        o_branch  = 1'b0;
        o_illegal = 1'b0;
        case (i_func3)
            3'b000, 3'b100, 3'b110: o_branch = i_result;
            3'b001, 3'b101, 3'b111: o_branch = ~i_result;
            default:                o_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_branch_q  <= 1'b0;
            o_illegal_q <= 1'b0;
            o_valid_q   <= 1'b0;
        end else begin
            o_branch_q  <= o_branch & i_valid;
            o_illegal_q <= o_illegal & i_valid;
            o_valid_q   <= i_valid;
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic count_legal;
    logic count_taken;

    // o_branch is already 0 for illegal encodings, so taken implies legal.
    assign count_legal = i_valid & ~o_illegal;
    assign count_taken = i_valid & o_branch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_total_cnt <= '0;
            o_taken_cnt <= '0;
        end else begin
            if (count_legal && (o_total_cnt != CNT_MAX)) begin
                o_total_cnt <= o_total_cnt + 1'b1;
            end
            if (count_taken && (o_taken_cnt != CNT_MAX)) begin
                o_taken_cnt <= o_taken_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_decision_unit.sv
// tb/tb_branch_decision_unit.sv - directed self-checking bench for branch_decision_unit

`timescale 1ns/1ps

module tb_branch_decision_unit;

    localparam int CNT_W = 4;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             i_result;
    logic [2:0]       i_func3;
    logic             o_branch;
    logic             o_illegal;
    logic             o_branch_q;
    logic             o_illegal_q;
    logic             o_valid_q;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] o_taken_cnt;
    logic [CNT_W-1:0] o_total_cnt;
`endif

    logic clk_en;
    int   tests_run;
    int   tests_failed;

    branch_decision_unit #(.CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_result    (i_result),
        .i_func3     (i_func3),
        .o_branch    (o_branch),
        .o_illegal   (o_illegal),
        .o_branch_q  (o_branch_q),
        .o_illegal_q (o_illegal_q),
`ifdef BRANCH_STATS_EN
        .o_valid_q   (o_valid_q),
        .o_taken_cnt (o_taken_cnt),
        .o_total_cnt (o_total_cnt)
`else
        .o_valid_q   (o_valid_q)
`endif
    );

    initial begin
        i_clk  = 1'b0;
        clk_en = 1'b0;
    end

    always #5 if (clk_en) i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive func3/result, let combinational logic settle, check both flags.
    task automatic comb_vec(input logic [2:0] f, input logic r, input logic exp_b, input logic exp_i);
        i_func3  = f;
        i_result = r;
        #1;
        check($sformatf("branch f=%03b r=%0b", f, r), {31'd0, o_branch}, {31'd0, exp_b});
        check($sformatf("illegal f=%03b r=%0b", f, r), {31'd0, o_illegal}, {31'd0, exp_i});
    endtask

    // Inputs are changed just after the falling edge; checks happen 1ns after the rising edge.
    task automatic drive(input logic v, input logic [2:0] f, input logic r);
        @(negedge i_clk);
        i_valid  = v;
        i_func3  = f;
        i_result = r;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_q(input string tag, input logic b, input logic il, input logic v);
        check({tag, " branch_q"},  {31'd0, o_branch_q},  {31'd0, b});
        check({tag, " illegal_q"}, {31'd0, o_illegal_q}, {31'd0, il});
        check({tag, " valid_q"},   {31'd0, o_valid_q},   {31'd0, v});
    endtask

    task automatic reset_pulse();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_result = 1'b0;
        i_func3  = 3'b000;
        #3;

        // Reset state, clock stopped.
        check_q("reset", 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        check("reset total_cnt", {28'd0, o_total_cnt}, 32'd0);
        check("reset taken_cnt", {28'd0, o_taken_cnt}, 32'd0);
`endif

        // Decode sweep with no clock and reset held: outputs must still be live.
        comb_vec(3'b000, 1'b1, 1'b1, 1'b0);
        comb_vec(3'b000, 1'b0, 1'b0, 1'b0);
        comb_vec(3'b001, 1'b0, 1'b1, 1'b0);
        comb_vec(3'b001, 1'b1, 1'b0, 1'b0);
        comb_vec(3'b100, 1'b0, 1'b0, 1'b0);
        comb_vec(3'b100, 1'b1, 1'b1, 1'b0);
        comb_vec(3'b101, 1'b1, 1'b0, 1'b0);
        comb_vec(3'b101, 1'b0, 1'b1, 1'b0);
        comb_vec(3'b110, 1'b0, 1'b0, 1'b0);
        comb_vec(3'b110, 1'b1, 1'b1, 1'b0);
        comb_vec(3'b111, 1'b1, 1'b0, 1'b0);
        comb_vec(3'b111, 1'b0, 1'b1, 1'b0);
        comb_vec(3'b010, 1'b0, 1'b0, 1'b1);
        comb_vec(3'b010, 1'b1, 1'b0, 1'b1);
        comb_vec(3'b011, 1'b0, 1'b0, 1'b1);
        comb_vec(3'b011, 1'b1, 1'b0, 1'b1);

        // Start the clock; release reset away from an edge.
        clk_en = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Registered path: valid BEQ taken, then bubble.
        drive(1'b1, 3'b000, 1'b1);
        check_q("beq taken", 1'b1, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b1);
        check_q("bubble", 1'b0, 1'b0, 1'b0);

        // Illegal encodings with a valid instruction.
        drive(1'b1, 3'b010, 1'b1);
        check_q("illegal 010", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'b011, 1'b0);
        check_q("illegal 011", 1'b0, 1'b1, 1'b1);
        // Invalid cycle with illegal func3 must not register the flag.
        drive(1'b0, 3'b011, 1'b0);
        check_q("illegal no valid", 1'b0, 1'b0, 1'b0);
        // Valid not-taken BGEU.
        drive(1'b1, 3'b111, 1'b1);
        check_q("bgeu not taken", 1'b0, 1'b0, 1'b1);

        // Async reset mid-cycle.
        drive(1'b1, 3'b001, 1'b0);
        check_q("bne taken", 1'b1, 1'b0, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_q("async reset", 1'b0, 1'b0, 1'b0);
        i_result = 1'b1;
        #1;
        check("branch live in reset", {31'd0, o_branch}, 32'd0);
        i_result = 1'b0;
        #1;
        check("branch live in reset 2", {31'd0, o_branch}, 32'd1);
        @(posedge i_clk);
        #1;
        check_q("held in reset", 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        check_q("after release idle", 1'b0, 1'b0, 1'b0);

`ifdef BRANCH_STATS_EN
        check("cnt after reset total", {28'd0, o_total_cnt}, 32'd0);
        check("cnt after reset taken", {28'd0, o_taken_cnt}, 32'd0);
        for (int k = 0; k < 4; k++) drive(1'b1, 3'b000, 1'b1);
        for (int k = 0; k < 2; k++) drive(1'b1, 3'b001, 1'b1);
        drive(1'b1, 3'b010, 1'b1);
        drive(1'b0, 3'b000, 1'b1);
        check("stats total", {28'd0, o_total_cnt}, 32'd6);
        check("stats taken", {28'd0, o_taken_cnt}, 32'd4);

        reset_pulse();
        #1;
        check("stats reset total", {28'd0, o_total_cnt}, 32'd0);
        for (int k = 0; k < 20; k++) drive(1'b1, 3'b110, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        check("sat total", {28'd0, o_total_cnt}, 32'd15);
        check("sat taken", {28'd0, o_taken_cnt}, 32'd15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
